// File: rtl/tetris_pkg.sv
// rtl/tetris_pkg.sv - shared types and default board geometry for the tetrimino controller
package tetris_pkg;

    localparam int XSIZE_DEF = 3;
    localparam int YSIZE_DEF = 3;

    typedef enum logic [2:0] {
        ST_SPAWN,
        ST_ISSUE,
        ST_SETTLE,
        ST_PLAY,
        ST_LOCK,
        ST_LOCKWAIT,
        ST_OVER
    } ctrl_state_t;

    typedef enum logic [2:0] {
        CMD_NONE,
        CMD_LOAD,
        CMD_DOWN,
        CMD_LEFT,
        CMD_RIGHT,
        CMD_LOCK
    } cmd_t;

endpackage

// File: rtl/piece_collide.sv
// rtl/piece_collide.sv - combinational check of four piece cells, shifted one step, against walls and locked cells
module piece_collide
    import tetris_pkg::*;
#(
    parameter int XSIZE = XSIZE_DEF,
    parameter int YSIZE = YSIZE_DEF
) (
    input  logic [3:0][XSIZE-1:0]              cx,
    input  logic [3:0][YSIZE-1:0]              cy,
    input  cmd_t                               dir,
    input  logic [2**YSIZE-1:0][2**XSIZE-1:0]  board,
    output logic                               blocked
);

    localparam logic [XSIZE-1:0] XMAX = '1;

    logic [XSIZE-1:0] nx;
    logic [YSIZE-1:0] ny;
    logic             wall;

    // The neighbour index only moves off the cell when the cell is not at the wall,
    // so a wrapped coordinate never reaches the board lookup.
    always_comb begin
        blocked = 1'b0;
        nx      = '0;
        ny      = '0;
        wall    = 1'b0;
        for (int i = 0; i < 4; i++) begin
            nx   = cx[i];
            ny   = cy[i];
            wall = 1'b0;
            case (dir)
                CMD_LEFT:  if (cx[i] == XMAX) wall = 1'b1; else nx = cx[i] + XSIZE'(1);
                CMD_RIGHT: if (cx[i] == '0)   wall = 1'b1; else nx = cx[i] - XSIZE'(1);
                CMD_DOWN:  if (cy[i] == '0)   wall = 1'b1; else ny = cy[i] - YSIZE'(1);
                default:   ;
            endcase
            if (wall || board[ny][nx]) blocked = 1'b1;
        end
    end

endmodule

// File: rtl/tetrimino_ctrl.sv
// rtl/tetrimino_ctrl.sv - turns buttons and gravity into load/move/lock pulses for the piece position register
module tetrimino_ctrl
    import tetris_pkg::*;
#(
    parameter int XSIZE      = XSIZE_DEF,
    parameter int YSIZE      = YSIZE_DEF,
    parameter int GRAV_TICKS = 50_000_000
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               btnLeft,
    input  logic                               btnRight,
    input  logic                               btnDown,
    input  logic [3:0][XSIZE-1:0]              curX,
    input  logic [3:0][YSIZE-1:0]              curY,
    input  logic                               spawnValid,
    input  logic [3:0][XSIZE-1:0]              spawnX,
    input  logic [3:0][YSIZE-1:0]              spawnY,
    input  logic [2**YSIZE-1:0][2**XSIZE-1:0]  board,
    output logic                               load,
    output logic                               down,
    output logic                               left,
    output logic                               right,
    output logic                               lock,
    output logic                               gameOver
);

    localparam int            GW        = $clog2(GRAV_TICKS);
    localparam logic [GW-1:0] GRAV_LAST = GW'(GRAV_TICKS - 1);

    ctrl_state_t   state_q, state_n;
    cmd_t          cmd_n;
    logic          blk_left, blk_right, blk_down, blk_spawn;
    logic          prev_l, prev_r, prev_d;
    logic          pend_l, pend_r, pend_d;
    logic          clr_l, clr_r, clr_d, take_tick, do_load;
    logic          tick, counting, wrap, in_over;
    logic [GW-1:0] grav_cnt;

    piece_collide #(.XSIZE(XSIZE), .YSIZE(YSIZE)) u_col_left (
        .cx(curX), .cy(curY), .dir(CMD_LEFT), .board(board), .blocked(blk_left));
    piece_collide #(.XSIZE(XSIZE), .YSIZE(YSIZE)) u_col_right (
        .cx(curX), .cy(curY), .dir(CMD_RIGHT), .board(board), .blocked(blk_right));
    piece_collide #(.XSIZE(XSIZE), .YSIZE(YSIZE)) u_col_down (
        .cx(curX), .cy(curY), .dir(CMD_DOWN), .board(board), .blocked(blk_down));
    piece_collide #(.XSIZE(XSIZE), .YSIZE(YSIZE)) u_col_spawn (
        .cx(spawnX), .cy(spawnY), .dir(CMD_NONE), .board(board), .blocked(blk_spawn));

    always_ff @(posedge clk) begin
        if (!reset) state_q <= ST_SPAWN;
        else        state_q <= state_n;
    end

    always_comb begin
        state_n   = state_q;
        cmd_n     = CMD_NONE;
        clr_l     = 1'b0;
        clr_r     = 1'b0;
        clr_d     = 1'b0;
        take_tick = 1'b0;
        do_load   = 1'b0;
        case (state_q)
            ST_SPAWN: if (spawnValid) begin
                if (blk_spawn) begin
                    state_n = ST_OVER;
                end else begin
                    state_n = ST_ISSUE;
                    cmd_n   = CMD_LOAD;
                    do_load = 1'b1;
                end
            end
            ST_ISSUE:  state_n = ST_SETTLE;
            ST_SETTLE: state_n = ST_PLAY;
            ST_PLAY: begin
                // A blocked down, whether from gravity or the soft-drop button, lands the piece.
                if (tick || pend_d) begin
                    take_tick = tick;
                    clr_d     = !tick;
                    state_n   = blk_down ? ST_LOCK : ST_ISSUE;
                    cmd_n     = blk_down ? CMD_LOCK : CMD_DOWN;
                end else if (pend_l) begin
                    clr_l = 1'b1;
                    if (!blk_left) begin
                        state_n = ST_ISSUE;
                        cmd_n   = CMD_LEFT;
                    end
                end else if (pend_r) begin
                    clr_r = 1'b1;
                    if (!blk_right) begin
                        state_n = ST_ISSUE;
                        cmd_n   = CMD_RIGHT;
                    end
                end
            end
            ST_LOCK:     state_n = ST_LOCKWAIT;
            ST_LOCKWAIT: state_n = ST_SPAWN;
            ST_OVER:     state_n = ST_OVER;
            default:     state_n = ST_SPAWN;
        endcase
    end

    assign in_over  = (state_q == ST_OVER);
    assign counting = (state_q == ST_ISSUE) || (state_q == ST_SETTLE) || (state_q == ST_PLAY);
    assign wrap     = counting && (grav_cnt == GRAV_LAST);

    always_ff @(posedge clk) begin
        if (!reset) begin
            {prev_l, prev_r, prev_d} <= '0;
            {pend_l, pend_r, pend_d} <= '0;
            grav_cnt <= '0;
            tick     <= 1'b0;
            {load, down, left, right, lock, gameOver} <= '0;
        end else begin
            prev_l <= btnLeft;
            prev_r <= btnRight;
            prev_d <= btnDown;
            pend_l <= (pend_l | (btnLeft  & ~prev_l & ~in_over)) & ~(clr_l | do_load);
            pend_r <= (pend_r | (btnRight & ~prev_r & ~in_over)) & ~(clr_r | do_load);
            pend_d <= (pend_d | (btnDown  & ~prev_d & ~in_over)) & ~(clr_d | do_load);
            if (do_load || wrap) grav_cnt <= '0;
            else if (counting)   grav_cnt <= grav_cnt + GW'(1);
            tick     <= !do_load && ((tick && !take_tick) || wrap);
            load     <= (cmd_n == CMD_LOAD);
            down     <= (cmd_n == CMD_DOWN);
            left     <= (cmd_n == CMD_LEFT);
            right    <= (cmd_n == CMD_RIGHT);
            lock     <= (cmd_n == CMD_LOCK);
            gameOver <= (state_n == ST_OVER);
        end
    end

endmodule
